// File: rtl/sprite_compositor_if.sv
// Pixel, configuration and collision signals between the sprite generators,
// the mask register writer and the compositor.
interface sprite_compositor_if #(
  parameter int NUM_LAYERS = 4,
  parameter int PIX_W      = 5
);
  localparam int LID_W = $clog2(NUM_LAYERS + 1);

  logic                        pixValidIn;
  logic                        frameStart;
  logic [NUM_LAYERS-1:0]       layerOn;
  logic [NUM_LAYERS*PIX_W-1:0] layerPixel;
  logic                        cfgWe;
  logic [NUM_LAYERS-1:0]       cfgMask;
  logic [PIX_W-1:0]            pixelOut;
  logic                        pixValidOut;
  logic [LID_W-1:0]            layerIdOut;
  logic [NUM_LAYERS-1:0]       collisionMask;
  logic                        collisionValid;

  modport master (
    output pixValidIn, frameStart, layerOn, layerPixel, cfgWe, cfgMask,
    input  pixelOut, pixValidOut, layerIdOut, collisionMask, collisionValid
  );

  modport slave (
    input  pixValidIn, frameStart, layerOn, layerPixel, cfgWe, cfgMask,
    output pixelOut, pixValidOut, layerIdOut, collisionMask, collisionValid
  );
endinterface

// File: rtl/sprite_compositor.sv
// N-layer priority pixel compositor, 2-cycle latency, frame-synchronised layer mask.
// Optional SPRITE_COMPOSITOR_COLLISION_EN builds the per-frame collision flags.
module sprite_compositor #(
  parameter int              NUM_LAYERS = 4,
  parameter int              PIX_W      = 5,
  parameter logic [PIX_W-1:0] TRANSP_IDX = PIX_W'(5'h15),
  parameter logic [PIX_W-1:0] BG_IDX     = PIX_W'(5'h11),
  parameter logic [PIX_W-1:0] RESET_IDX  = PIX_W'(5'h15)
) (
  input  logic               Clk,
  input  logic               Reset,
  sprite_compositor_if.slave bus
);
  localparam int LID_W = $clog2(NUM_LAYERS + 1);

  logic [NUM_LAYERS-1:0]       pendingMask;
  logic [NUM_LAYERS-1:0]       activeMask;
  logic [NUM_LAYERS-1:0]       maskNow;
  logic [NUM_LAYERS-1:0]       opaque;
  logic                        s1Valid;
  logic [NUM_LAYERS-1:0]       s1Opaque;
  logic [NUM_LAYERS*PIX_W-1:0] s1Pixel;
  logic [PIX_W-1:0]            winPix;
  logic [LID_W-1:0]            winId;
  logic [PIX_W-1:0]            pixelQ;
  logic [LID_W-1:0]            layerIdQ;
  logic                        pixValidQ;

  // The frame-start pixel must already see the mask it promotes.
  assign maskNow = (bus.pixValidIn && bus.frameStart) ? pendingMask : activeMask;

  always_comb begin
    opaque = '0;
    for (int i = 0; i < NUM_LAYERS; i++)
      opaque[i] = bus.layerOn[i] & maskNow[i] &
                  (bus.layerPixel[i*PIX_W +: PIX_W] != TRANSP_IDX);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pendingMask <= '1;
      activeMask  <= '1;
      s1Valid     <= 1'b0;
    end else begin
      if (bus.cfgWe)
        pendingMask <= bus.cfgMask;
      if (bus.pixValidIn && bus.frameStart)
        activeMask <= pendingMask;
      s1Valid <= bus.pixValidIn;
    end
  end

  always_ff @(posedge Clk) begin
    s1Opaque <= opaque;
    s1Pixel  <= bus.layerPixel;
  end

  // Scan from lowest priority upward so the lowest opaque index wins.
  always_comb begin
    winPix = BG_IDX;
    winId  = LID_W'(NUM_LAYERS);
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (s1Opaque[i]) begin
        winPix = s1Pixel[i*PIX_W +: PIX_W];
        winId  = LID_W'(i);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pixelQ    <= RESET_IDX;
      layerIdQ  <= LID_W'(NUM_LAYERS);
      pixValidQ <= 1'b0;
    end else begin
      pixValidQ <= s1Valid;
      if (s1Valid) begin
        pixelQ   <= winPix;
        layerIdQ <= winId;
      end
    end
  end

  assign bus.pixelOut    = pixelQ;
  assign bus.layerIdOut  = layerIdQ;
  assign bus.pixValidOut = pixValidQ;

`ifdef SPRITE_COMPOSITOR_COLLISION_EN
  logic                  s1Frame;
  logic [3:0]            numOpaque;
  logic                  multiOpaque;
  logic [NUM_LAYERS-1:0] acc;
  logic [NUM_LAYERS-1:0] collMaskQ;
  logic                  collValidQ;

  always_ff @(posedge Clk) begin
    s1Frame <= bus.frameStart;
  end

  always_comb begin
    numOpaque = 4'd0;
    for (int i = 0; i < NUM_LAYERS; i++)
      numOpaque = numOpaque + 4'(s1Opaque[i]);
  end

  assign multiOpaque = (numOpaque >= 4'd2);

  // The frame-start pixel closes the old frame and seeds the new one.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc        <= '0;
      collMaskQ  <= '0;
      collValidQ <= 1'b0;
    end else begin
      collValidQ <= 1'b0;
      if (s1Valid) begin
        if (s1Frame) begin
          collMaskQ  <= acc;
          collValidQ <= 1'b1;
          acc        <= multiOpaque ? s1Opaque : '0;
        end else if (multiOpaque) begin
          acc <= acc | s1Opaque;
        end
      end
    end
  end

  assign bus.collisionMask  = collMaskQ;
  assign bus.collisionValid = collValidQ;
`else
  assign bus.collisionMask  = '0;
  assign bus.collisionValid = 1'b0;
`endif
endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised N-layer pixel compositor between the per-sprite pixel generators and the frame buffer write path. Each cycle it takes one palette index per layer, discards layers that are off, masked or transparent, and outputs the highest-priority surviving index, or the background index if none survive. It also keeps per-frame layer-collision flags and a frame-synchronised layer-enable mask. Fully pipelined, one pixel per cycle, fixed 2-cycle latency.

## Interface

- NUM_LAYERS, 4, number of sprite layers (1..8); layer 0 has the highest priority
- PIX_W, 5, palette index width
- TRANSP_IDX, 5'h15, index treated as transparent on any layer
- BG_IDX, 5'h11, index output when no layer is opaque
- RESET_IDX, 5'h15, value of pixelOut after reset

- Clk  in  1  clock
- Reset  in  1  synchronous, active-high
- pixValidIn  in  1  input pixel qualifier
- frameStart  in  1  first pixel of a frame; only meaningful when pixValidIn=1
- layerOn  in  NUM_LAYERS  per-layer "current pixel lies inside the sprite"
- layerPixel  in  NUM_LAYERS*PIX_W  layer i index at bits [i*PIX_W +: PIX_W]
- cfgWe  in  1  write strobe for the pending layer mask
- cfgMask  in  NUM_LAYERS  pending layer-enable mask
- pixelOut  out  PIX_W  composited index
- pixValidOut  out  1  pixValidIn delayed by 2 cycles
- layerIdOut  out  $clog2(NUM_LAYERS+1)  winning layer; the value NUM_LAYERS means background
- collisionMask  out  NUM_LAYERS  collision flags for the previous frame
- collisionValid  out  1  one-cycle pulse when collisionMask updates

## Operation

- Stage 1 (registered): for each layer i, opaque[i] = layerOn[i] & activeMask[i] & (layerPixel[i] != TRANSP_IDX). Register opaque[], the pixels, pixValidIn and frameStart.
- Stage 2 (registered): the lowest-index opaque layer wins. Set pixelOut to its pixel and layerIdOut to i. If no layer is opaque, pixelOut=BG_IDX and layerIdOut=NUM_LAYERS.
- When stage-2 valid is 0: pixelOut and layerIdOut hold their last values, and pixValidOut=0.
- Layer mask:
  - cfgWe writes cfgMask into pendingMask.
  - activeMask <= pendingMask on any cycle with frameStart & pixValidIn. The new mask therefore applies starting with that frame-start pixel.
  - If cfgWe and frameStart occur in the same cycle, cfgMask goes into pendingMask only. activeMask takes the old pendingMask value.
- Collision accumulation:
  - Computed at stage 2, for valid pixels only.
  - If popcount(opaque) >= 2, then acc |= opaque.
  - When a valid stage-2 pixel carries frameStart: collisionMask <= acc, collisionValid=1, and acc <= (popcount>=2 ? opaque : 0). The frame-start pixel therefore counts toward the new frame.
- Reset values:
  - pixelOut=RESET_IDX, layerIdOut=NUM_LAYERS, pixValidOut=0
  - collisionMask=0, collisionValid=0, acc=0
  - pendingMask and activeMask all ones
  - pipeline valid bits cleared
- Reset mid-frame drops the in-flight pixels. No collisionValid pulse is produced until the next frameStart reaches stage 2.

## Timing

- Latency: 2 cycles from pixValidIn to pixValidOut. Throughput: 1 pixel/cycle, with no stall and no backpressure.
- frameStart on cycle t gives collisionValid on cycle t+2, aligned with that pixel's pixValidOut.
- A cfgWe on cycle t affects pixels that enter at or after the first frameStart strictly later than t.
- activeMask is sampled in stage 1 in the same cycle it updates. Use a bypass so the frame-start pixel sees the new mask.

## Configuration

- SPRITE_COMPOSITOR_COLLISION_EN:
  - Defined: collision accumulation, collisionMask and collisionValid function as described.
  - Undefined: the acc logic is not built, and collisionMask and collisionValid are tied to 0. Compositing and mask behaviour are identical in both builds.

## Test plan

- Reset, then NUM_LAYERS=4 with all layerOn=0 and valid pixels → pixelOut=5'h11, layerIdOut=4 two cycles later. Before any valid pixel: pixelOut=5'h15 and pixValidOut=0.
- Layers 1 and 3 on with pixels 5'h03 and 5'h07 → pixelOut=5'h03, layerIdOut=1. Set layer 1's pixel to 5'h15 → pixelOut=5'h07, layerIdOut=3.
- cfgWe with cfgMask=4'b1101 mid-frame → no effect until the next frameStart. From the frame-start pixel on, layer 1 is ignored: with pixels 5'h03 and 5'h07 as above, pixelOut=5'h07.
- Frame A has layers 0 and 2 overlapping on one pixel; frame B has no overlap → collisionMask=4'b0101 with collisionValid at B's frameStart+2, then 4'b0000 at the following frameStart+2.
- Assert Reset mid-frame with an overlap already accumulated → outputs return to their reset values and no stale collisionValid appears. The next full frame reports only its own collisions.
- Build without SPRITE_COMPOSITOR_COLLISION_EN, repeat the frame-A stimulus → collisionMask=0 and collisionValid never asserts; pixelOut is identical to the collision-enabled build.
